// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store stage that turns execute results into data-memory transactions and retires them.
module mem_access_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [4:0]            rd_i,
  input  logic                  reg_write_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [3:0]            dmem_be,
  input  logic                  dmem_ack,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  valid_o,
  output logic                  reg_write_o,
  output logic                  misaligned_o,
  output logic [4:0]            rd_o,
  output logic [DATA_WIDTH-1:0] result_o
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic mem_op, store, is_b, is_h, aligned, accept, killed;
  logic kill_q, load_q, rw_q, sign_q;
  logic [1:0] lane_q, size_q;
  logic [4:0] rd_q;
  logic [3:0] be_n;
  logic [DATA_WIDTH-1:0] wdata_n, shifted, load_data;
  assign mem_op  = mem_read_i | mem_write_i;
  assign store   = mem_write_i;
  assign is_b    = funct3_i == 3'b000 || (!store && funct3_i == 3'b100);
  assign is_h    = funct3_i == 3'b001 || (!store && funct3_i == 3'b101);
  assign aligned = is_b || (is_h ? !addr_i[0] : addr_i[1:0] == 2'b00);
  assign accept  = state == IDLE && valid_i && mem_op && aligned && !flush_i;
  assign be_n    = is_b ? 4'b0001 << addr_i[1:0] : is_h ? 4'b0011 << addr_i[1:0] : 4'b1111;
  assign wdata_n = is_b ? {4{wdata_i[7:0]}} : is_h ? {2{wdata_i[15:0]}} : wdata_i;
  assign killed  = kill_q | flush_i;
  // size_q: 0 byte, 1 half, 2 word; shifting by the lane leaves the wanted bytes at the bottom
  assign shifted   = dmem_rdata >> {lane_q, 3'b000};
  assign load_data = size_q == 2'd0 ? {{24{sign_q & shifted[7]}}, shifted[7:0]} :
                     size_q == 2'd1 ? {{16{sign_q & shifted[15]}}, shifted[15:0]} : shifted;
  always_comb begin
    state_n = state == IDLE ? (accept ? BUSY : IDLE) : (dmem_ack ? IDLE : BUSY);
    stall_o = state == IDLE ? accept : !dmem_ack;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o      <= 1'b0;
      reg_write_o  <= 1'b0;
      misaligned_o <= 1'b0;
      rd_o         <= '0;
      result_o     <= '0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_be      <= '0;
      kill_q       <= 1'b0;
      load_q       <= 1'b0;
      rw_q         <= 1'b0;
      sign_q       <= 1'b0;
      lane_q       <= '0;
      size_q       <= '0;
      rd_q         <= '0;
    end else begin
      valid_o      <= 1'b0;
      reg_write_o  <= 1'b0;
      misaligned_o <= 1'b0;
      if (state == IDLE) begin
        if (valid_i && !flush_i && !mem_op) begin
          valid_o     <= 1'b1;
          result_o    <= addr_i;
          rd_o        <= rd_i;
          reg_write_o <= reg_write_i;
        end else if (valid_i && !flush_i && !aligned) begin
          valid_o      <= 1'b1;
          misaligned_o <= 1'b1;
          result_o     <= addr_i;
          rd_o         <= rd_i;
        end else if (accept) begin
          dmem_req   <= 1'b1;
          dmem_we    <= store;
          dmem_addr  <= {addr_i[DATA_WIDTH-1:2], 2'b00};
          dmem_be    <= be_n;
          dmem_wdata <= wdata_n;
          kill_q     <= 1'b0;
          load_q     <= !store;
          rw_q       <= reg_write_i & !store;
          sign_q     <= !funct3_i[2];
          lane_q     <= addr_i[1:0];
          size_q     <= is_b ? 2'd0 : is_h ? 2'd1 : 2'd2;
          rd_q       <= rd_i;
        end
      end else begin
        if (flush_i) kill_q <= 1'b1;
        if (dmem_ack) begin
          dmem_req    <= 1'b0;
          valid_o     <= !killed;
          reg_write_o <= rw_q & !killed;
          rd_o        <= rd_q;
          result_o    <= load_q ? load_data : '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: vector table, random ops against a byte-level model, and reset/idle corner sequences.
module tb_mem_access_unit;
  logic clk = 0, rst = 1, valid_i = 0, mem_read_i = 0, mem_write_i = 0, flush_i = 0, reg_write_i = 0, dmem_ack = 0;
  logic [2:0] funct3_i = 0;
  logic [31:0] addr_i = 0, wdata_i = 0, dmem_rdata = 0;
  logic [4:0] rd_i = 0;
  logic stall_o, dmem_req, dmem_we, valid_o, reg_write_o, misaligned_o;
  logic [31:0] dmem_addr, dmem_wdata, result_o;
  logic [3:0] dmem_be;
  logic [4:0] rd_o;
  int checks = 0, errors = 0;

  mem_access_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i), .rd_i(rd_i), .reg_write_i(reg_write_i),
    .flush_i(flush_i), .stall_o(stall_o), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .valid_o(valid_o), .reg_write_o(reg_write_o), .misaligned_o(misaligned_o), .rd_o(rd_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rd, wr; logic [2:0] f3; logic [31:0] addr, wdata; logic [4:0] rdi; logic rw;
    int wait_n; logic [31:0] rdata; logic fi, fb;
  } op_t;
  typedef struct {
    int stall, busy; logic req, we; logic [31:0] daddr, wd; logic [3:0] be;
    logic valid, rw, mis; logic [4:0] rd; logic [31:0] res;
  } res_t;
  typedef struct { op_t op; res_t ex; } vec_t;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, act, exp);
    end
  endtask

  task automatic run(input op_t op, output res_t o);
    int busy;
    bit done;
    o = '{default: 0};
    busy = 0;
    done = 0;
    @(negedge clk);
    valid_i = 1; mem_read_i = op.rd; mem_write_i = op.wr; funct3_i = op.f3; addr_i = op.addr;
    wdata_i = op.wdata; rd_i = op.rdi; reg_write_i = op.rw; flush_i = op.fi; dmem_ack = 0;
    #1 if (stall_o) o.stall++;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (!dmem_req) begin
        o.valid = valid_o; o.rw = reg_write_o; o.mis = misaligned_o; o.rd = rd_o; o.res = result_o;
        done = 1;
        break;
      end
      if (busy == 0) begin
        o.req = 1; o.we = dmem_we; o.daddr = dmem_addr; o.be = dmem_be; o.wd = dmem_wdata;
      end
      dmem_ack = (busy == op.wait_n);
      dmem_rdata = dmem_ack ? op.rdata : $urandom;
      flush_i = op.fb && busy == 0;
      #1 if (stall_o) o.stall++;
      busy++;
    end
    o.busy = busy;
    valid_i = 0; flush_i = 0; dmem_ack = 0;
    chk("completed", 32'(done), 32'd1);
  endtask

  function automatic res_t model(input op_t op);
    res_t e;
    int size, lane;
    logic mem, st, mis, acc;
    logic [31:0] v;
    e = '{default: 0};
    mem = op.rd | op.wr;
    st = op.wr;
    size = st ? (op.f3 == 0 ? 1 : op.f3 == 1 ? 2 : 4) : (op.f3[1:0] == 0 ? 1 : op.f3[1:0] == 1 ? 2 : 4);
    lane = int'(op.addr % 4);
    mis = mem && (op.addr % size) != 0;
    acc = mem && !mis && !op.fi;
    e.req = acc;
    e.we = st;
    e.daddr = op.addr & ~32'd3;
    e.be = 4'(((1 << size) - 1) << lane);
    for (int i = 0; i < 4; i++) e.wd[8*i +: 8] = op.wdata[8*(i % size) +: 8];
    v = 0;
    for (int i = 0; i < size; i++) v[8*i +: 8] = op.rdata[8*(lane + i) +: 8];
    if (size < 4 && !op.f3[2] && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 1);
    e.stall = acc ? 1 + op.wait_n : 0;
    e.busy = acc ? op.wait_n + 1 : 0;
    e.valid = !op.fi && !(acc && op.fb);
    e.mis = e.valid && mis;
    e.rw = e.valid && (!mem ? op.rw : (acc && !st && op.rw));
    e.rd = op.rdi;
    e.res = (!mem || mis) ? op.addr : (st ? 32'd0 : v);
    return e;
  endfunction

  task automatic compare(input string t, input op_t op, input res_t e, input res_t o);
    chk({t, " stall"}, 32'(o.stall), 32'(e.stall));
    chk({t, " req"}, 32'(o.req), 32'(e.req));
    if (e.req) begin
      chk({t, " latency"}, 32'(o.busy), 32'(e.busy));
      chk({t, " we"}, 32'(o.we), 32'(e.we));
      chk({t, " daddr"}, o.daddr, e.daddr);
      if (op.wr) begin
        chk({t, " be"}, 32'(o.be), 32'(e.be));
        chk({t, " wdata"}, o.wd, e.wd);
      end
    end
    chk({t, " valid"}, 32'(o.valid), 32'(e.valid));
    chk({t, " reg_write"}, 32'(o.rw), 32'(e.rw));
    chk({t, " misaligned"}, 32'(o.mis), 32'(e.mis));
    if (e.valid) begin
      chk({t, " rd"}, 32'(o.rd), 32'(e.rd));
      chk({t, " result"}, o.res, e.res);
    end
  endtask

  vec_t vt[14];
  res_t o;
  op_t op;

  initial begin
    // {rd,wr,f3,addr,wdata,rdi,rw,wait,rdata,fi,fb} -> {stall,busy,req,we,daddr,wd,be,valid,rw,mis,rd,res}
    vt[0]  = '{'{0,0,3'b000,32'h1234,0,5,1,0,0,0,0},        '{0,0,0,0,0,0,0,1,1,0,5,32'h1234}};
    vt[1]  = '{'{1,0,3'b000,32'h103,0,7,1,3,32'h8000_0000,0,0}, '{4,4,1,0,32'h100,0,0,1,1,0,7,32'hFFFF_FF80}};
    vt[2]  = '{'{0,1,3'b001,32'h202,32'hDEAD_BEEF,3,1,0,0,0,0}, '{1,1,1,1,32'h200,32'hBEEF_BEEF,4'b1100,1,0,0,3,0}};
    vt[3]  = '{'{1,0,3'b010,32'h301,0,9,1,0,0,0,0},        '{0,0,0,0,0,0,0,1,0,1,9,32'h301}};
    vt[4]  = '{'{1,0,3'b010,32'h400,0,4,1,1,32'h1234_5678,0,1}, '{2,2,1,0,32'h400,0,0,0,0,0,0,0}};
    vt[5]  = '{'{1,0,3'b101,32'h106,0,2,1,0,32'h8765_4321,0,0}, '{1,1,1,0,32'h104,0,0,1,1,0,2,32'h0000_8765}};
    vt[6]  = '{'{1,0,3'b001,32'h106,0,2,1,2,32'h8765_4321,0,0}, '{3,3,1,0,32'h104,0,0,1,1,0,2,32'hFFFF_8765}};
    vt[7]  = '{'{1,0,3'b100,32'h101,0,6,1,0,32'h1122_A533,0,0}, '{1,1,1,0,32'h100,0,0,1,1,0,6,32'h0000_00A5}};
    vt[8]  = '{'{0,1,3'b000,32'h003,32'h1234_5678,1,1,0,0,0,0}, '{1,1,1,1,32'h000,32'h7878_7878,4'b1000,1,0,0,1,0}};
    vt[9]  = '{'{0,0,3'b000,32'h55,0,8,1,0,0,1,0},          '{0,0,0,0,0,0,0,0,0,0,0,0}};
    vt[10] = '{'{1,0,3'b111,32'h10C,0,10,1,0,32'hCAFE_F00D,0,0}, '{1,1,1,0,32'h10C,0,0,1,1,0,10,32'hCAFE_F00D}};
    vt[11] = '{'{0,1,3'b100,32'h208,32'h0102_0304,1,1,0,0,0,0}, '{1,1,1,1,32'h208,32'h0102_0304,4'b1111,1,0,0,1,0}};
    vt[12] = '{'{1,1,3'b010,32'h20C,32'hAAAA_5555,12,1,1,32'hFFFF_FFFF,0,0}, '{2,2,1,1,32'h20C,32'hAAAA_5555,4'b1111,1,0,0,12,0}};
    vt[13] = '{'{0,1,3'b110,32'h002,0,13,1,0,0,0,0},         '{0,0,0,0,0,0,0,1,0,1,13,32'h002}};
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    chk("reset valid_o", 32'(valid_o), 0);
    chk("reset dmem_req", 32'(dmem_req), 0);
    chk("reset dmem_addr", dmem_addr, 0);
    chk("reset dmem_be", 32'(dmem_be), 0);
    chk("reset result_o", result_o, 0);
    chk("reset stall_o", 32'(stall_o), 0);
    for (int i = 0; i < 14; i++) begin
      run(vt[i].op, o);
      compare($sformatf("vec%0d", i), vt[i].op, vt[i].ex, o);
    end
    // pulses drop in the idle cycle after a retire
    run(vt[0].op, o);
    @(negedge clk);
    chk("pulse valid_o", 32'(valid_o), 0);
    chk("pulse reg_write_o", 32'(reg_write_o), 0);
    // ack while idle is ignored
    dmem_ack = 1;
    #1 chk("idle ack stall", 32'(stall_o), 0);
    @(negedge clk);
    dmem_ack = 0;
    chk("idle ack valid_o", 32'(valid_o), 0);
    chk("idle ack dmem_req", 32'(dmem_req), 0);
    // reset during a bus transaction
    valid_i = 1; mem_read_i = 1; mem_write_i = 0; funct3_i = 3'b010; addr_i = 32'h500; rd_i = 3; reg_write_i = 1;
    @(negedge clk);
    chk("rst busy req", 32'(dmem_req), 1);
    rst = 1; valid_i = 0;
    @(negedge clk);
    rst = 0;
    chk("rst busy drop req", 32'(dmem_req), 0);
    dmem_ack = 1; dmem_rdata = 32'h1111_2222;
    @(negedge clk);
    dmem_ack = 0;
    chk("rst late ack valid", 32'(valid_o), 0);
    @(negedge clk);
    chk("rst late ack valid2", 32'(valid_o), 0);
    chk("rst late ack req", 32'(dmem_req), 0);
    for (int n = 0; n < 300; n++) begin
      op.rd = 1'($urandom_range(0, 2) != 0);
      op.wr = 1'($urandom_range(0, 2) == 0);
      op.f3 = 3'($urandom);
      op.addr = $urandom;
      op.wdata = $urandom;
      op.rdi = 5'($urandom);
      op.rw = 1'($urandom);
      op.wait_n = $urandom_range(0, 3);
      op.rdata = $urandom;
      op.fi = $urandom_range(0, 9) == 0;
      op.fb = $urandom_range(0, 9) == 0;
      if ($urandom_range(0, 2) != 0) op.addr[1:0] = 2'b00;
      run(op, o);
      compare($sformatf("rnd%0d", n), op, model(op), o);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
